// File: rtl/cpu7_excp_ctl_pkg.sv
// cpu7_excp_ctl_pkg
//   Shared definitions for the exception/interrupt sequencer:
//   - sequencer state encoding
//   - exception codes (ECODE) written to ESTAT
//   - bit positions inside the interrupt status vector
//   - badv source select used between the priority encoder and the top
package cpu7_excp_ctl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_REDIR  = 2'd3
   } excp_state_t;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_INE  = 6'h0D;

   // Interrupt status bit positions
   localparam int IS_SWI0 = 0;
   localparam int IS_SWI1 = 1;
   localparam int IS_HWI0 = 2;
   localparam int IS_HWI7 = 9;
   localparam int IS_TI   = 11;
   localparam int IS_IPI  = 12;

   typedef enum logic [1:0] {
      BADV_ZERO  = 2'd0,
      BADV_PC    = 2'd1,
      BADV_VADDR = 2'd2
   } badv_sel_t;

endpackage

// File: rtl/cpu7_excp_prio.sv
// cpu7_excp_prio
//   Purely combinational priority encoder for the instruction at _e.
//   Priority (highest first): interrupt, adef, ine, sys, brk, ale, ertn.
//   An exception on an ertn instruction wins; the ertn is dropped.
// Ports:
//   intr, adef, ine, sys, brk, ale, ertn : cause flags
//   hit      : any cause present
//   code     : exception code of the winning cause (0 for interrupt/ertn)
//   badv_sel : which address feeds badv for the winning cause
//   is_ertn  : the winning cause is ertn (no exception present)
module cpu7_excp_prio
   import cpu7_excp_ctl_pkg::*;
(
   input  logic       intr,
   input  logic       adef,
   input  logic       ine,
   input  logic       sys,
   input  logic       brk,
   input  logic       ale,
   input  logic       ertn,
   output logic       hit,
   output logic [5:0] code,
   output badv_sel_t  badv_sel,
   output logic       is_ertn
);

   always_comb begin
      hit      = 1'b1;
      code     = ECODE_INT;
      badv_sel = BADV_ZERO;
      is_ertn  = 1'b0;
      if (intr) begin
         code = ECODE_INT;
      end else if (adef) begin
         code     = ECODE_ADEF;
         badv_sel = BADV_PC;
      end else if (ine) begin
         code = ECODE_INE;
      end else if (sys) begin
         code = ECODE_SYS;
      end else if (brk) begin
         code = ECODE_BRK;
      end else if (ale) begin
         code     = ECODE_ALE;
         badv_sel = BADV_VADDR;
      end else if (ertn) begin
         is_ertn = 1'b1;
      end else begin
         hit = 1'b0;
      end
   end

endmodule

// File: rtl/cpu7_excp_ctl.sv
// cpu7_excp_ctl
//   Exception/interrupt sequencer between the execute stage (_e) and the
//   CSR file. Picks the highest priority cause for the _e instruction,
//   drains the pipeline, issues a single-cycle commit pulse into the CSR
//   file and then redirects fetch to eentry (exception) or era (ertn).
//
//   Flow: IDLE -(event)-> DRAIN -(lsu_idle)-> COMMIT -> REDIR -> IDLE
//
// Optional build macro:
//   CPU7_EXCP_INTR_SYNC_EN : hardware interrupt lines csr_is[HWI7:HWI0]
//                            pass through a 2-flop synchronizer before
//                            the interrupt term (+2 cycles latency).
//
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   valid_e, pc_e, vaddr_e: _e instruction valid, PC, memory address
//   exc_*_e, ertn_e       : cause flags of the _e instruction
//   csr_is, csr_lie       : interrupt status / local enable
//   csr_crmd_ie           : global interrupt enable
//   csr_eentry, csr_era   : redirect targets, sampled in REDIR
//   lsu_idle              : no outstanding memory operations
//   excp_stall_e          : hold _e (event cycle and every non-IDLE state)
//   excp_flush            : kill younger instructions (DRAIN)
//   exu_ifu_except        : exception commit pulse with exccode/badv/era_pc
//   ertn_commit           : ertn commit pulse
//   redirect_vld/pc       : fetch redirect strobe and target
//   excp_state            : current sequencer state (observation only)
module cpu7_excp_ctl
   import cpu7_excp_ctl_pkg::*;
#(
   parameter int GRLEN  = 32,
   parameter int NUM_IS = 13
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              valid_e,
   input  logic [GRLEN-1:0]  pc_e,
   input  logic [GRLEN-1:0]  vaddr_e,
   input  logic              exc_adef_e,
   input  logic              exc_ine_e,
   input  logic              exc_sys_e,
   input  logic              exc_brk_e,
   input  logic              exc_ale_e,
   input  logic              ertn_e,
   input  logic [NUM_IS-1:0] csr_is,
   input  logic [NUM_IS-1:0] csr_lie,
   input  logic              csr_crmd_ie,
   input  logic [GRLEN-1:0]  csr_eentry,
   input  logic [GRLEN-1:0]  csr_era,
   input  logic              lsu_idle,
   output logic              excp_stall_e,
   output logic              excp_flush,
   output logic              exu_ifu_except,
   output logic [5:0]        exccode,
   output logic [GRLEN-1:0]  badv,
   output logic [GRLEN-1:0]  era_pc,
   output logic              ertn_commit,
   output logic              redirect_vld,
   output logic [GRLEN-1:0]  redirect_pc,
   output logic [1:0]        excp_state
);

   excp_state_t      state;
   excp_state_t      state_nxt;

   logic [NUM_IS-1:0] is_eff;
   logic              intr;
   logic              hit;
   logic [5:0]        prio_code;
   badv_sel_t         prio_badv_sel;
   logic              prio_ertn;
   logic              take;
   logic [GRLEN-1:0]  badv_mux;

   logic [5:0]        cap_code;
   logic [GRLEN-1:0]  cap_badv;
   logic [GRLEN-1:0]  cap_pc;
   logic              cap_ertn;

   // ------------------------------------------------------------------
   // Interrupt status path
   // ------------------------------------------------------------------
`ifdef CPU7_EXCP_INTR_SYNC_EN
   logic [IS_HWI7:IS_HWI0] hwi_s1;
   logic [IS_HWI7:IS_HWI0] hwi_s2;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hwi_s1 <= '0;
         hwi_s2 <= '0;
      end else begin
         hwi_s1 <= csr_is[IS_HWI7:IS_HWI0];
         hwi_s2 <= hwi_s1;
      end
   end

   always_comb begin
      is_eff                  = csr_is;
      is_eff[IS_HWI7:IS_HWI0] = hwi_s2;
   end
`else
   assign is_eff = csr_is;
`endif

   // Level-sensitive, never latched: re-evaluated every IDLE cycle.
   assign intr = csr_crmd_ie & (|(is_eff & csr_lie));

   cpu7_excp_prio u_prio (
      .intr     (intr),
      .adef     (exc_adef_e),
      .ine      (exc_ine_e),
      .sys      (exc_sys_e),
      .brk      (exc_brk_e),
      .ale      (exc_ale_e),
      .ertn     (ertn_e),
      .hit      (hit),
      .code     (prio_code),
      .badv_sel (prio_badv_sel),
      .is_ertn  (prio_ertn)
   );

   // resetn gates the event term so that the combinational stall stays
   // low while reset is held, even if the pipeline presents an event.
   assign take = resetn & (state == ST_IDLE) & valid_e & hit;

   always_comb begin
      case (prio_badv_sel)
         BADV_PC:    badv_mux = pc_e;
         BADV_VADDR: badv_mux = vaddr_e;
         default:    badv_mux = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Capture of the event taken in IDLE
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cap_code <= '0;
         cap_badv <= '0;
         cap_pc   <= '0;
         cap_ertn <= 1'b0;
      end else if (take) begin
         cap_code <= prio_code;
         cap_badv <= badv_mux;
         cap_pc   <= pc_e;
         cap_ertn <= prio_ertn;
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (take) state_nxt = ST_DRAIN;
         ST_DRAIN:  if (lsu_idle) state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = ST_REDIR;
         ST_REDIR:  state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (commit/redirect payloads are zero outside their cycle)
   // ------------------------------------------------------------------
   always_comb begin
      excp_stall_e   = 1'b0;
      excp_flush     = 1'b0;
      exu_ifu_except = 1'b0;
      exccode        = '0;
      badv           = '0;
      era_pc         = '0;
      ertn_commit    = 1'b0;
      redirect_vld   = 1'b0;
      redirect_pc    = '0;
      case (state)
         ST_IDLE: begin
            excp_stall_e = take;
         end
         ST_DRAIN: begin
            excp_stall_e = 1'b1;
            excp_flush   = 1'b1;
         end
         ST_COMMIT: begin
            excp_stall_e = 1'b1;
            if (cap_ertn) begin
               ertn_commit = 1'b1;
            end else begin
               exu_ifu_except = 1'b1;
               exccode        = cap_code;
               badv           = cap_badv;
               era_pc         = cap_pc;
            end
         end
         ST_REDIR: begin
            excp_stall_e = 1'b1;
            redirect_vld = 1'b1;
            // CSR values are read live here so a write made during
            // COMMIT is already visible.
            redirect_pc  = cap_ertn ? csr_era : csr_eentry;
         end
         default: ;
      endcase
   end

   assign excp_state = state;

endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// tb_cpu7_excp_ctl
//   Self-checking bench for cpu7_excp_ctl: directed scenarios with literal
//   expectations, then randomized traffic compared every cycle against a
//   transaction-level model (event -> drain until lsu_idle -> commit ->
//   redirect). Inputs change 1 time unit after posedge; outputs are
//   compared on negedge.
module tb_cpu7_excp_ctl;

   localparam int GRLEN  = 32;
   localparam int NUM_IS = 13;
   localparam int TI     = 11;

   logic              clk;
   logic              resetn;
   logic              valid_e;
   logic [GRLEN-1:0]  pc_e;
   logic [GRLEN-1:0]  vaddr_e;
   logic              exc_adef_e, exc_ine_e, exc_sys_e, exc_brk_e, exc_ale_e;
   logic              ertn_e;
   logic [NUM_IS-1:0] csr_is;
   logic [NUM_IS-1:0] csr_lie;
   logic              csr_crmd_ie;
   logic [GRLEN-1:0]  csr_eentry;
   logic [GRLEN-1:0]  csr_era;
   logic              lsu_idle;
   logic              excp_stall_e;
   logic              excp_flush;
   logic              exu_ifu_except;
   logic [5:0]        exccode;
   logic [GRLEN-1:0]  badv;
   logic [GRLEN-1:0]  era_pc;
   logic              ertn_commit;
   logic              redirect_vld;
   logic [GRLEN-1:0]  redirect_pc;
   logic [1:0]        excp_state;

   cpu7_excp_ctl #(.GRLEN(GRLEN), .NUM_IS(NUM_IS)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .valid_e        (valid_e),
      .pc_e           (pc_e),
      .vaddr_e        (vaddr_e),
      .exc_adef_e     (exc_adef_e),
      .exc_ine_e      (exc_ine_e),
      .exc_sys_e      (exc_sys_e),
      .exc_brk_e      (exc_brk_e),
      .exc_ale_e      (exc_ale_e),
      .ertn_e         (ertn_e),
      .csr_is         (csr_is),
      .csr_lie        (csr_lie),
      .csr_crmd_ie    (csr_crmd_ie),
      .csr_eentry     (csr_eentry),
      .csr_era        (csr_era),
      .lsu_idle       (lsu_idle),
      .excp_stall_e   (excp_stall_e),
      .excp_flush     (excp_flush),
      .exu_ifu_except (exu_ifu_except),
      .exccode        (exccode),
      .badv           (badv),
      .era_pc         (era_pc),
      .ertn_commit    (ertn_commit),
      .redirect_vld   (redirect_vld),
      .redirect_pc    (redirect_pc),
      .excp_state     (excp_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard counters ----------------
   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"},  excp_stall_e,   0);
      chk({tag, "_flush"},  excp_flush,     0);
      chk({tag, "_except"}, exu_ifu_except, 0);
      chk({tag, "_code"},   exccode,        0);
      chk({tag, "_badv"},   badv,           0);
      chk({tag, "_era"},    era_pc,         0);
      chk({tag, "_ertn"},   ertn_commit,    0);
      chk({tag, "_rvld"},   redirect_vld,   0);
      chk({tag, "_rpc"},    redirect_pc,    0);
   endtask

   // ---------------- reference model ----------------
   // One outstanding transaction: its cause, plus its age in cycles since
   // the event and the age at which it commits (unknown while draining).
   logic        m_active = 1'b0;
   int          m_age = 0;
   int          m_commit_at = -1;
   logic [5:0]  m_code = '0;
   logic [31:0] m_badv = '0;
   logic [31:0] m_pc = '0;
   logic        m_ertn = 1'b0;
   logic [7:0]  m_hwi_d1 = '0;
   logic [7:0]  m_hwi_d2 = '0;

   task automatic pick_cause(input logic intr, output logic [5:0] c,
                             output logic [31:0] b, output logic er);
      c = 6'h00; b = '0; er = 1'b0;
      if (intr)             c = 6'h00;
      else if (exc_adef_e)  begin c = 6'h08; b = pc_e; end
      else if (exc_ine_e)   c = 6'h0D;
      else if (exc_sys_e)   c = 6'h0B;
      else if (exc_brk_e)   c = 6'h0C;
      else if (exc_ale_e)   begin c = 6'h09; b = vaddr_e; end
      else                  er = 1'b1;
   endtask

   always @(negedge clk) begin : compare
      logic              e_stall, e_flush, e_exc, e_ertn, e_rvld;
      logic              intr, ev, start, done;
      logic [NUM_IS-1:0] is_eff;
      logic [5:0]        c;
      logic [31:0]       b;
      logic              er;
      int                next_commit;
      if (!resetn) begin
         chk_all_zero("rst_hold");
         m_active = 1'b0;
         m_hwi_d1 = '0;
         m_hwi_d2 = '0;
      end else begin
         e_stall = 0; e_flush = 0; e_exc = 0; e_ertn = 0; e_rvld = 0;
         start = 0; done = 0; next_commit = m_commit_at;
         c = 0; b = 0; er = 0;
         is_eff = csr_is;
`ifdef CPU7_EXCP_INTR_SYNC_EN
         is_eff[9:2] = m_hwi_d2;
`endif
         intr = csr_crmd_ie && ((is_eff & csr_lie) != 0);
         if (!m_active) begin
            ev = valid_e && (intr || exc_adef_e || exc_ine_e || exc_sys_e ||
                             exc_brk_e || exc_ale_e || ertn_e);
            e_stall = ev;
            if (ev) begin
               pick_cause(intr, c, b, er);
               start = 1;
            end
         end else begin
            e_stall = 1;
            if (m_commit_at < 0) begin
               e_flush = 1;
               if (lsu_idle) next_commit = m_age + 1;
            end else if (m_age == m_commit_at) begin
               e_exc  = !m_ertn;
               e_ertn = m_ertn;
            end else begin
               e_rvld = 1;
               done   = 1;
            end
         end
         chk("stall",  excp_stall_e,   e_stall);
         chk("flush",  excp_flush,     e_flush);
         chk("except", exu_ifu_except, e_exc);
         chk("ertn",   ertn_commit,    e_ertn);
         chk("rvld",   redirect_vld,   e_rvld);
         if (e_exc) begin
            chk("code", exccode, m_code);
            chk("badv", badv,    m_badv);
            chk("era",  era_pc,  m_pc);
         end
         if (e_rvld) chk("rpc", redirect_pc, m_ertn ? csr_era : csr_eentry);
         // advance the model to the next cycle
         if (start) begin
            m_active = 1; m_age = 1; m_commit_at = -1;
            m_code = c; m_badv = b; m_pc = pc_e; m_ertn = er;
         end else if (m_active) begin
            m_commit_at = next_commit;
            if (done) m_active = 0;
            m_age++;
         end
         m_hwi_d2 = m_hwi_d1;
         m_hwi_d1 = csr_is[9:2];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_instr();
      valid_e = 0; exc_adef_e = 0; exc_ine_e = 0; exc_sys_e = 0;
      exc_brk_e = 0; exc_ale_e = 0; ertn_e = 0;
   endtask

   task automatic test_ale();
      step();
      pc_e = 32'h1C00_0040; vaddr_e = 32'h0000_1002; exc_ale_e = 1; valid_e = 1; lsu_idle = 1;
      @(negedge clk); chk("ale_stall_n", excp_stall_e, 1);
      step(); clear_instr();
      @(negedge clk); chk("ale_flush_n1", excp_flush, 1);
      step();
      @(negedge clk);
      chk("ale_except_n2", exu_ifu_except, 1);
      chk("ale_code", exccode, 6'h09);
      chk("ale_badv", badv, 32'h0000_1002);
      chk("ale_era", era_pc, 32'h1C00_0040);
      step();
      @(negedge clk);
      chk("ale_rvld_n3", redirect_vld, 1);
      chk("ale_rpc", redirect_pc, 32'h1C00_8000);
      step();
      @(negedge clk); chk("ale_idle_n4", excp_stall_e, 0);
   endtask

   task automatic test_drain();
      step();
      pc_e = 32'h1C00_0080; exc_sys_e = 1; valid_e = 1; lsu_idle = 0;
      @(negedge clk); chk("drn_stall_n", excp_stall_e, 1);
      step(); clear_instr();
      for (int i = 0; i < 4; i++) begin
         lsu_idle = (i == 3);
         @(negedge clk);
         chk("drn_flush", excp_flush, 1);
         chk("drn_no_commit", exu_ifu_except, 0);
         step();
      end
      @(negedge clk);
      chk("drn_except", exu_ifu_except, 1);
      chk("drn_code", exccode, 6'h0B);
      chk("drn_badv", badv, 0);
      chk("drn_era", era_pc, 32'h1C00_0080);
      step();
      @(negedge clk); chk("drn_rvld", redirect_vld, 1);
   endtask

   task automatic test_intr_vs_brk();
      step();
      csr_is = 13'd1 << TI; csr_lie = 13'd1 << TI; csr_crmd_ie = 1;
      pc_e = 32'h1C00_00C0; exc_brk_e = 1; valid_e = 1; lsu_idle = 1;
      @(negedge clk); chk("int_stall_n", excp_stall_e, 1);
      step(); clear_instr(); csr_crmd_ie = 0; csr_is = 0;
      @(negedge clk); chk("int_flush", excp_flush, 1);
      step();
      @(negedge clk);
      chk("int_except", exu_ifu_except, 1);
      chk("int_code", exccode, 6'h00);
      chk("int_badv", badv, 0);
      chk("int_era", era_pc, 32'h1C00_00C0);
      step();
      @(negedge clk); chk("int_rpc", redirect_pc, 32'h1C00_8000);
   endtask

   task automatic test_masked();
      step();
      csr_crmd_ie = 0; csr_is = 13'd1 << TI; csr_lie = '1; valid_e = 1;
      @(negedge clk); chk("msk_stall", excp_stall_e, 0);
      step(); clear_instr(); csr_is = 0;
      @(negedge clk); chk("msk_flush", excp_flush, 0);
   endtask

   task automatic test_valid0();
      step();
      csr_crmd_ie = 1; csr_is = 13'd1 << TI; csr_lie = 13'd1 << TI; valid_e = 0;
      @(negedge clk); chk("v0_stall", excp_stall_e, 0);
      step(); csr_crmd_ie = 0; csr_is = 0;
      @(negedge clk); chk("v0_flush", excp_flush, 0);
   endtask

   task automatic test_ertn();
      step();
      csr_era = 32'h1C00_0100; pc_e = 32'h1C00_0200; ertn_e = 1; valid_e = 1; lsu_idle = 1;
      @(negedge clk); chk("ert_stall_n", excp_stall_e, 1);
      step(); clear_instr();
      @(negedge clk); chk("ert_flush", excp_flush, 1);
      step();
      @(negedge clk);
      chk("ert_commit_n2", ertn_commit, 1);
      chk("ert_no_except", exu_ifu_except, 0);
      step();
      @(negedge clk);
      chk("ert_rvld_n3", redirect_vld, 1);
      chk("ert_rpc", redirect_pc, 32'h1C00_0100);
      chk("ert_no_except3", exu_ifu_except, 0);
   endtask

   task automatic test_reset_mid();
      step();
      pc_e = 32'h1C00_0300; vaddr_e = 32'h0000_2001; exc_ale_e = 1; valid_e = 1; lsu_idle = 1;
      @(negedge clk);
      step(); clear_instr();
      @(negedge clk);
      step();
      chk("rmid_in_commit", exu_ifu_except, 1);
      resetn = 0;
      #1;
      chk_all_zero("rmid");
      chk("rmid_state", excp_state, 0);
      @(negedge clk);
      step(); resetn = 1;
      @(negedge clk);
      chk("rmid_state_after", excp_state, 0);
      chk("rmid_stall_after", excp_stall_e, 0);
      step();
      @(negedge clk); chk("rmid_no_redirect", redirect_vld, 0);
   endtask

   task automatic drive_random();
      valid_e     = ($urandom_range(0, 3) != 0);
      pc_e        = $urandom;
      vaddr_e     = $urandom;
      exc_adef_e  = ($urandom_range(0, 11) == 0);
      exc_ine_e   = ($urandom_range(0, 11) == 0);
      exc_sys_e   = ($urandom_range(0, 11) == 0);
      exc_brk_e   = ($urandom_range(0, 11) == 0);
      exc_ale_e   = ($urandom_range(0, 11) == 0);
      ertn_e      = ($urandom_range(0, 7) == 0);
      csr_is      = NUM_IS'($urandom & $urandom & $urandom);
      csr_lie     = NUM_IS'($urandom);
      csr_crmd_ie = $urandom_range(0, 1);
      lsu_idle    = ($urandom_range(0, 4) < 3);
      if ($urandom_range(0, 9) == 0) csr_eentry = $urandom;
      if ($urandom_range(0, 9) == 0) csr_era = $urandom;
   endtask

   // ---------------- main sequence and final report ----------------
   initial begin
      resetn = 0;
      clear_instr();
      pc_e = 0; vaddr_e = 0; csr_is = 0; csr_lie = 0; csr_crmd_ie = 0;
      csr_eentry = 32'h1C00_8000; csr_era = 0; lsu_idle = 1;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      chk("reset_state", excp_state, 0);
      resetn = 1;
      step();
      test_ale();
      test_drain();
      test_intr_vs_brk();
      test_masked();
      test_valid0();
      test_ertn();
      test_reset_mid();
      for (int i = 0; i < 3000; i++) begin
         step();
         drive_random();
      end
      step();
      clear_instr();
      csr_is = 0; lsu_idle = 1;
      repeat (8) step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
